max_search_ctrl: RTL

//   Sequencer that time-shares one WIDTH-bit "A > B" magnitude comparator to find the maximum
//   of a COUNT-element stream. Elements arrive over a valid/ready handshake. An FSM tracks the

---
 rtl/max_search_ctrl.sv | 123 ++++++++++++
 1 files changed

// File: rtl/max_search_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : max_search_ctrl
//  Brief    : Streams COUNT unsigned elements over valid/ready and finds the
//             maximum, the index of its first occurrence and the number of
//             strict improvements, using one time-shared "A > B" comparator.
//  Revision : 1.0 - initial release
// ============================================================================
module max_search_ctrl #(
    parameter  int WIDTH = 3,
    parameter  int COUNT = 8,
    localparam int IW    = $clog2(COUNT)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] max_out,
    output logic [IW-1:0]    max_idx,
    output logic [IW-1:0]    gt_count
);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_LOAD = 2'd1;
    localparam logic [1:0] c_CMP  = 2'd2;
    localparam logic [1:0] c_DONE = 2'd3;

    // Index of the final element; its transfer closes the run.
    localparam logic [IW-1:0] c_LAST = IW'(COUNT - 1);

    logic [1:0]       state_q, state_d;
    logic [IW-1:0]    cnt_q,   cnt_d;
    logic [WIDTH-1:0] max_q,   max_d;
    logic [IW-1:0]    idx_q,   idx_d;
    logic [IW-1:0]    gtc_q,   gtc_d;

    logic w_xfer;
    logic w_gt;

    // Moore handshake/status outputs decoded purely from state, so there is
    // no combinational path from in_valid back to in_ready.
    assign in_ready = (state_q == c_LOAD) || (state_q == c_CMP);
    assign busy     = in_ready;
    assign done     = (state_q == c_DONE);
    assign w_xfer   = in_valid && in_ready;

    // The single shared magnitude comparator: strict, unsigned, so ties keep
    // the earliest index.
    assign w_gt     = (in_data > max_q);

    assign max_out  = max_q;
    assign max_idx  = idx_q;
    assign gt_count = gtc_q;

    // Next-state and datapath update logic; everything holds unless a
    // transfer or a state step happens.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        max_d   = max_q;
        idx_d   = idx_q;
        gtc_d   = gtc_q;
        case (state_q)
            c_IDLE: begin
                if (start) begin
                    state_d = c_LOAD;
                    cnt_d   = '0;
                end
            end
            c_LOAD: begin
                if (w_xfer) begin
                    max_d   = in_data;
                    idx_d   = '0;
                    gtc_d   = '0;
                    cnt_d   = IW'(1);
                    state_d = c_CMP;
                end
            end
            c_CMP: begin
                if (w_xfer) begin
                    if (w_gt) begin
                        max_d = in_data;
                        idx_d = cnt_q;
                        gtc_d = gtc_q + IW'(1);
                    end
                    cnt_d = cnt_q + IW'(1);
                    if (cnt_q == c_LAST) begin
                        state_d = c_DONE;
                    end
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    // State registers; reset overrides everything and discards a partial run.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= c_IDLE;
            cnt_q   <= '0;
            max_q   <= '0;
            idx_q   <= '0;
            gtc_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            idx_q   <= idx_d;
            gtc_q   <= gtc_d;
        end
    end

endmodule
`default_nettype wire
